pl_io_ports: RTL and testbench

PL_IO_PORTS -- requirements
Module: pl_io_ports

---
 rtl/pl_io_pkg.sv | 14 +
 rtl/pl_io_sync_chan.sv | 46 ++++
 rtl/pl_io_ports.sv | 89 ++++++++
 tb/tb_pl_io_ports.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pl_io_pkg.sv
// Shared defaults and derived-width helper for the parallel I/O port block.
package pl_io_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_OUT_RESET   = 0;

  // Channel-select width: clog2 of the channel count, never below one bit.
  function automatic int unsigned addr_w(input int unsigned n_ch);
    return (n_ch > 1) ? int'($clog2(n_ch)) : 1;
  endfunction

endpackage

// File: rtl/pl_io_sync_chan.sv
// One input channel: synchronizer chain, previous-value register and sticky
// change flag.
//   clk, rst  : clock, async active-high reset
//   din       : raw asynchronous input
//   clr       : read-side clear of the change flag
//   sync_out  : synchronized value (last stage of the chain)
//   chg_flag  : sticky "input changed" flag
module pl_io_sync_chan #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] sync_out,
  output logic              chg_flag
);

  logic [DATA_W-1:0] stage [SYNC_STAGES];
  logic [DATA_W-1:0] prev;

  // Synchronizer shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
    end
  end

  assign sync_out = stage[SYNC_STAGES-1];

  // A fresh mismatch overrides a simultaneous read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      chg_flag <= 1'b0;
    end else begin
      prev     <= sync_out;
      chg_flag <= (sync_out != prev) | (chg_flag & ~clr);
    end
  end

endmodule

// File: rtl/pl_io_ports.sv
// Parallel I/O port block: N_CH synchronized inputs with change flags and
// interrupt, N_CH CPU-writable registered outputs.
//   clk, rst             : clock, async active-high reset
//   in_port / out_port   : packed channels, channel i at [i*DATA_W +: DATA_W]
//   cpu_addr             : channel select for read and write
//   cpu_we, cpu_wdata    : output register write
//   cpu_re               : read of synchronized input, clears its change flag
//   cpu_rdata, cpu_rvalid: registered read data and one-cycle qualifier
//   chg_flag, irq        : sticky per-channel change flags and their OR
module pl_io_ports
  import pl_io_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       N_CH        = DEF_N_CH,
  parameter int unsigned       SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [DATA_W-1:0] OUT_RESET   = DATA_W'(DEF_OUT_RESET),
  localparam int unsigned      ADDR_W      = addr_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_port,
  output logic [N_CH*DATA_W-1:0] out_port,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic                   cpu_we,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_re,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_rvalid,
  output logic [N_CH-1:0]        chg_flag,
  output logic                   irq
);

  logic [N_CH-1:0]        sel_c;
  logic [N_CH*DATA_W-1:0] sync_c;
  logic [DATA_W-1:0]      rd_mux_c;

  // One-hot channel decode; out-of-range addresses select nothing.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) sel_c[i] = (cpu_addr == ADDR_W'(i));
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    pl_io_sync_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din      (in_port[g*DATA_W +: DATA_W]),
      .clr      (cpu_re & sel_c[g]),
      .sync_out (sync_c[g*DATA_W +: DATA_W]),
      .chg_flag (chg_flag[g])
    );
  end

  // Read mux; zero when no channel is selected.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel_c[i]) rd_mux_c = sync_c[i*DATA_W +: DATA_W];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port <= {N_CH{OUT_RESET}};
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cpu_we && sel_c[i]) out_port[i*DATA_W +: DATA_W] <= cpu_wdata;
      end
    end
  end

  // Read data, valid pulse and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_re;
      if (cpu_re) cpu_rdata <= rd_mux_c;
      irq <= |chg_flag;
    end
  end

endmodule

// File: tb/tb_pl_io_ports.sv
// Directed bench: a 4-channel instance (OUT_RESET 0) and a 3-channel instance
// (OUT_RESET 8'hA5) share clock and reset.
module tb_pl_io_ports;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0] in_port, out_port;
  logic [1:0]  cpu_addr;
  logic        cpu_we, cpu_re, cpu_rvalid, irq;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [3:0]  chg_flag;

  // 3-channel instance
  logic [23:0] in3, out3;
  logic [1:0]  addr3;
  logic        we3, re3, rvalid3, irq3;
  logic [7:0]  wdata3, rdata3;
  logic [2:0]  chg3;

  pl_io_ports #(.DATA_W(8), .N_CH(4), .SYNC_STAGES(2), .OUT_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .in_port(in_port), .out_port(out_port),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .chg_flag(chg_flag), .irq(irq)
  );

  pl_io_ports #(.DATA_W(8), .N_CH(3), .SYNC_STAGES(2), .OUT_RESET(8'hA5)) dut3 (
    .clk(clk), .rst(rst), .in_port(in3), .out_port(out3),
    .cpu_addr(addr3), .cpu_we(we3), .cpu_wdata(wdata3),
    .cpu_re(re3), .cpu_rdata(rdata3), .cpu_rvalid(rvalid3),
    .chg_flag(chg3), .irq(irq3)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] in;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] e_out;
    logic [7:0]  e_rdata;
    logic        e_rv;
    logic [3:0]  e_chg;
    logic        e_irq;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] in, input logic we, input logic re,
                              input logic [1:0] addr, input logic [7:0] wdata,
                              input logic [31:0] e_out, input logic [7:0] e_rdata,
                              input logic e_rv, input logic [3:0] e_chg, input logic e_irq);
    vec_t v;
    v.in = in; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.e_out = e_out; v.e_rdata = e_rdata; v.e_rv = e_rv; v.e_chg = e_chg; v.e_irq = e_irq;
    return v;
  endfunction

  initial begin
    //            in            we    re    ad    wd     out           rd     rv    chg      irq
    tbl[0]  = mk(32'h00000000, 1'b0, 1'b0, 2'd0, 8'h00, 32'h00000000, 8'h00, 1'b0, 4'b0000, 1'b0);
    tbl[1]  = mk(32'h00000000, 1'b1, 1'b0, 2'd1, 8'h5A, 32'h00005A00, 8'h00, 1'b0, 4'b0000, 1'b0);
    tbl[2]  = mk(32'h00000000, 1'b1, 1'b0, 2'd3, 8'hC3, 32'hC3005A00, 8'h00, 1'b0, 4'b0000, 1'b0);
    tbl[3]  = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A00, 8'h00, 1'b0, 4'b0000, 1'b0);
    tbl[4]  = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A00, 8'h00, 1'b0, 4'b0000, 1'b0);
    tbl[5]  = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A00, 8'h00, 1'b0, 4'b0100, 1'b0);
    tbl[6]  = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A00, 8'h00, 1'b0, 4'b0100, 1'b1);
    tbl[7]  = mk(32'h003C0000, 1'b0, 1'b1, 2'd2, 8'h00, 32'hC3005A00, 8'h3C, 1'b1, 4'b0000, 1'b1);
    tbl[8]  = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A00, 8'h3C, 1'b0, 4'b0000, 1'b0);
    tbl[9]  = mk(32'h003C0000, 1'b1, 1'b1, 2'd0, 8'h11, 32'hC3005A11, 8'h00, 1'b1, 4'b0000, 1'b0);
    tbl[10] = mk(32'h003C0000, 1'b0, 1'b1, 2'd2, 8'h00, 32'hC3005A11, 8'h3C, 1'b1, 4'b0000, 1'b0);
    tbl[11] = mk(32'h003C0000, 1'b0, 1'b1, 2'd3, 8'h00, 32'hC3005A11, 8'h00, 1'b1, 4'b0000, 1'b0);
    tbl[12] = mk(32'h003C0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'hC3005A11, 8'h00, 1'b0, 4'b0000, 1'b0);

    rst = 1'b1;
    in_port = '0; cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
    in3 = '0; addr3 = '0; we3 = 1'b0; re3 = 1'b0; wdata3 = '0;

    // Reset values before any clock edge, then after two edges.
    #1;
    check("rst_async_out", 64'(out_port), 64'h0);
    check("rst_async_out3", 64'(out3), 64'hA5A5A5);
    tick(); tick();
    check("rst_held_4ch", 64'({out_port, cpu_rdata, cpu_rvalid, chg_flag, irq}), 64'h0);
    check("rst_held_3ch", 64'({out3, rdata3, rvalid3, chg3, irq3}), 64'({24'hA5A5A5, 8'h00, 1'b0, 3'b000, 1'b0}));
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      in_port = tbl[i].in; cpu_we = tbl[i].we; cpu_re = tbl[i].re;
      cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      tick();
      check($sformatf("vec%0d", i), 64'({out_port, cpu_rdata, cpu_rvalid, chg_flag, irq}),
            64'({tbl[i].e_out, tbl[i].e_rdata, tbl[i].e_rv, tbl[i].e_chg, tbl[i].e_irq}));
    end
    cpu_we = 1'b0; cpu_re = 1'b0;

    // Read clear colliding with a new change on channel 0.
    in_port = 32'h003C0001;
    tick(); tick(); tick();
    check("coll_set01", 64'(chg_flag), 64'h1);
    in_port = 32'h003C0002; cpu_re = 1'b1; cpu_addr = 2'd0;
    tick();
    check("coll_clr01", 64'({cpu_rdata, cpu_rvalid, chg_flag}), 64'({8'h01, 1'b1, 4'b0000}));
    cpu_re = 1'b0;
    tick();
    check("coll_wait", 64'({cpu_rvalid, chg_flag}), 64'({1'b0, 4'b0000}));
    cpu_re = 1'b1;
    tick();
    check("coll_same_edge", 64'({cpu_rdata, cpu_rvalid, chg_flag}), 64'({8'h02, 1'b1, 4'b0001}));
    tick();
    check("coll_reread", 64'({cpu_rdata, cpu_rvalid, chg_flag, irq}), 64'({8'h02, 1'b1, 4'b0000, 1'b1}));
    cpu_re = 1'b0;

    // 3-channel instance: out-of-range address.
    we3 = 1'b1; addr3 = 2'd1; wdata3 = 8'h77;
    tick();
    check("n3_write1", 64'(out3), 64'hA577A5);
    we3 = 1'b0; in3 = 24'h000900;
    tick(); tick(); tick();
    check("n3_flag1", 64'(chg3), 64'h2);
    in3 = 24'h000905; re3 = 1'b1; addr3 = 2'd1;
    tick();
    check("n3_read1", 64'({rdata3, rvalid3, chg3}), 64'({8'h09, 1'b1, 3'b000}));
    re3 = 1'b0;
    tick(); tick();
    check("n3_flag0", 64'({rvalid3, chg3}), 64'({1'b0, 3'b001}));
    we3 = 1'b1; re3 = 1'b1; addr3 = 2'd3; wdata3 = 8'hFF;
    tick();
    check("n3_addr3", 64'({out3, rdata3, rvalid3, chg3}), 64'({24'hA577A5, 8'h00, 1'b1, 3'b001}));
    we3 = 1'b0; re3 = 1'b0;

    // Async reset while a read pulse is in flight.
    in_port = 32'h003C1202;
    tick(); tick(); tick();
    check("mid_flag1", 64'(chg_flag), 64'h2);
    cpu_re = 1'b1; cpu_addr = 2'd2;
    tick();
    check("mid_read", 64'({cpu_rdata, cpu_rvalid, irq}), 64'({8'h3C, 1'b1, 1'b1}));
    cpu_re = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_4ch", 64'({out_port, cpu_rdata, cpu_rvalid, chg_flag, irq}), 64'h0);
    check("mid_rst_3ch", 64'({out3, rvalid3, chg3, irq3}), 64'({24'hA5A5A5, 1'b0, 3'b000, 1'b0}));
    #2 rst = 1'b0;

    // Nonzero inputs after release are reported; all-zero channel 3 is not.
    tick(); tick();
    check("post_rst_wait", 64'(chg_flag), 64'h0);
    tick();
    check("post_rst_flags", 64'({chg_flag, chg3}), 64'({4'b0111, 3'b011}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
